// File: rtl/spw_tx_char_encoder.sv
// SpaceWire transmit character encoder: selects FCT / N-char / NULL, applies odd parity,
// serialises Data-Strobe one bit per bit_tick and tracks the TX credit count.
module spw_tx_char_encoder #(
    parameter int DWIDTH   = 9,
    parameter int CRED_MAX = 56
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic              bit_tick,
    input  logic              send_fct,
    input  logic              fct_received,
    input  logic              fifo_valid,
    input  logic [DWIDTH-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              fct_sent,
    output logic [5:0]        credit,
    output logic              credit_error,
    output logic              busy,
    output logic              dout,
    output logic              sout
);

    localparam logic [5:0] CRED_LIMIT = 6'(CRED_MAX - 8);

    logic [3:0] rem;
    logic [8:0] shreg;
    logic       hist;
    logic       fct_pending;
    logic       first_done;
    logic       en_q;

    logic       sel;
    logic       nchar_ok;
    logic       sel_fct;
    logic       sel_data;
    logic       credit_inc;
    logic       credit_ovf;
    logic       next_bit;
    logic [7:0] d_rev;
    logic [9:0] char_bits;
    logic [3:0] char_len;
    logic       char_hist;

    assign sel        = tx_enable && bit_tick && (rem == 4'd0);
    assign nchar_ok   = fifo_valid && (credit != 6'd0);
    assign sel_fct    = sel && fct_pending;
    assign sel_data   = sel && !fct_pending && nchar_ok;
    assign credit_inc = fct_received && (credit <= CRED_LIMIT);
    assign credit_ovf = fct_received && (credit > CRED_LIMIT);
    assign fct_sent   = sel_fct;
    assign busy       = (rem != 4'd0) || (en_q && !first_done);
    assign next_bit   = (rem == 4'd0) ? char_bits[9] : shreg[8];

    // Character image is left-aligned, first transmitted bit in bit 9. The parity of an
    // ESC or FCT is ~(hist ^ 1) = hist; the FCT half of a NULL always follows ESC bits 1,1.
    always_comb begin
        d_rev     = '0;
        char_bits = '0;
        char_len  = 4'd8;
        char_hist = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d_rev[7-i] = fifo_data[i];
        end
        if (fct_pending) begin
            char_bits = {hist, 3'b100, 6'b0};
            char_len  = 4'd4;
            char_hist = 1'b0;
        end else if (nchar_ok) begin
            if (fifo_data[DWIDTH-1]) begin
                char_bits = (fifo_data[7:0] == 8'd0) ? {hist, 3'b101, 6'b0}
                                                     : {hist, 3'b110, 6'b0};
                char_len  = 4'd4;
                char_hist = 1'b1;
            end else begin
                char_bits = {~hist, 1'b0, d_rev};
                char_len  = 4'd10;
                char_hist = ^fifo_data[7:0];
            end
        end else begin
            char_bits = {hist, 7'b1110100, 2'b0};
            char_len  = 4'd8;
            char_hist = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rem          <= '0;
            shreg        <= '0;
            hist         <= 1'b0;
            fct_pending  <= 1'b0;
            first_done   <= 1'b0;
            en_q         <= 1'b0;
            fifo_rd_en   <= 1'b0;
            credit       <= '0;
            credit_error <= 1'b0;
            dout         <= 1'b0;
            sout         <= 1'b0;
        end else if (!tx_enable) begin
            rem         <= '0;
            shreg       <= '0;
            hist        <= 1'b0;
            fct_pending <= 1'b0;
            first_done  <= 1'b0;
            en_q        <= 1'b0;
            fifo_rd_en  <= 1'b0;
            credit      <= '0;
            dout        <= 1'b0;
            sout        <= 1'b0;
        end else begin
            en_q        <= 1'b1;
            fifo_rd_en  <= sel_data;
            fct_pending <= send_fct || (fct_pending && !sel_fct);
            credit      <= credit + (credit_inc ? 6'd8 : 6'd0) - (sel_data ? 6'd1 : 6'd0);
            if (credit_ovf) begin
                credit_error <= 1'b1;
            end
            if (bit_tick) begin
                dout <= next_bit;
                sout <= sout ^ ~(next_bit ^ dout);
                if (rem == 4'd0) begin
                    shreg <= char_bits[8:0];
                    rem   <= char_len - 4'd1;
                    hist  <= char_hist;
                end else begin
                    shreg <= {shreg[7:0], 1'b0};
                    rem   <= rem - 4'd1;
                    if (rem == 4'd1) begin
                        first_done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spw_tx_char_encoder.sv
// Directed bench for spw_tx_char_encoder: line bits, Data-Strobe, credit and FIFO handshake.
module tb_spw_tx_char_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tx_enable = 1'b0;
    logic       bit_tick = 1'b0;
    logic       send_fct = 1'b0;
    logic       fct_received = 1'b0;
    logic       fifo_valid = 1'b0;
    logic [8:0] fifo_data = '0;
    logic       fifo_rd_en;
    logic       fct_sent;
    logic [5:0] credit;
    logic       credit_error;
    logic       busy;
    logic       dout;
    logic       sout;

    int total = 0;
    int bad   = 0;
    int n_fs  = 0;
    int n_rd  = 0;
    logic [9:0] bits;

    spw_tx_char_encoder dut (
        .clock(clock), .reset(reset), .tx_enable(tx_enable), .bit_tick(bit_tick),
        .send_fct(send_fct), .fct_received(fct_received), .fifo_valid(fifo_valid),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .fct_sent(fct_sent),
        .credit(credit), .credit_error(credit_error), .busy(busy), .dout(dout), .sout(sout)
    );

    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One line bit; every bit must toggle exactly one of dout/sout.
    task automatic tick(input logic frx, output logic b);
        logic pd, ps;
        pd = dout;
        ps = sout;
        bit_tick = 1'b1;
        fct_received = frx;
        #3;
        if (fct_sent) n_fs++;
        @(posedge clock);
        #1;
        bit_tick = 1'b0;
        fct_received = 1'b0;
        if (fifo_rd_en) n_rd++;
        b = dout;
        chk("ds_one_toggle", 32'((dout ^ pd) ^ (sout ^ ps)), 32'd1);
    endtask

    task automatic get_char(input int n, input logic frx, output logic [9:0] cb);
        logic b;
        cb = '0;
        n_fs = 0;
        n_rd = 0;
        for (int i = 0; i < n; i++) begin
            tick((i == 0) ? frx : 1'b0, b);
            cb = {cb[8:0], b};
        end
    endtask

    task automatic pulse_frx();
        fct_received = 1'b1;
        cyc();
        fct_received = 1'b0;
    endtask

    initial begin
        // reset values
        cyc(); cyc();
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_sout", 32'(sout), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_cerr", 32'(credit_error), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(fifo_rd_en), 32'd0);
        chk("rst_fs", 32'(fct_sent), 32'd0);
        reset = 1'b0;
        cyc();

        // two NULLs with no credit
        tx_enable = 1'b1;
        cyc();
        chk("busy_first", 32'(busy), 32'd1);
        get_char(8, 1'b0, bits);
        chk("null1", 32'(bits), 32'b01110100);
        chk("busy_idle", 32'(busy), 32'd0);
        fifo_valid = 1'b1;
        fifo_data  = 9'h041;
        get_char(8, 1'b0, bits);
        chk("null_nocred", 32'(bits), 32'b01110100);
        chk("rd_nocred", 32'(n_rd), 32'd0);

        // one FCT received -> data 0x41
        pulse_frx();
        chk("credit_8", 32'(credit), 32'd8);
        get_char(10, 1'b0, bits);
        chk("data_41", 32'(bits), 32'b1010000010);
        chk("rd_41", 32'(n_rd), 32'd1);
        chk("credit_7", 32'(credit), 32'd7);

        // queued FCT goes before queued data
        fifo_data = 9'h0A5;
        send_fct = 1'b1;
        cyc();
        send_fct = 1'b0;
        get_char(4, 1'b0, bits);
        chk("fct", 32'(bits), 32'b0100);
        chk("fct_sent_once", 32'(n_fs), 32'd1);
        chk("fct_no_rd", 32'(n_rd), 32'd0);
        get_char(10, 1'b0, bits);
        chk("data_a5", 32'(bits), 32'b1010100101);
        chk("rd_a5", 32'(n_rd), 32'd1);
        chk("credit_6", 32'(credit), 32'd6);
        fifo_data = 9'h001;
        get_char(10, 1'b0, bits);
        chk("data_01", 32'(bits), 32'b1010000000);
        chk("credit_5", 32'(credit), 32'd5);
        fifo_valid = 1'b0;
        get_char(8, 1'b0, bits);
        chk("null_hist1", 32'(bits), 32'b11110100);

        // abort mid data char
        fifo_valid = 1'b1;
        fifo_data  = 9'h0FF;
        get_char(4, 1'b0, bits);
        chk("data_ff_head", 32'(bits), 32'b1011);
        chk("credit_4", 32'(credit), 32'd4);
        tx_enable  = 1'b0;
        fifo_valid = 1'b0;
        cyc();
        chk("abort_dout", 32'(dout), 32'd0);
        chk("abort_sout", 32'(sout), 32'd0);
        chk("abort_credit", 32'(credit), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        tx_enable = 1'b1;
        cyc();
        chk("reen_busy", 32'(busy), 32'd1);
        get_char(8, 1'b0, bits);
        chk("reen_null", 32'(bits), 32'b01110100);

        // credit ceiling and overflow error
        for (int i = 0; i < 6; i++) pulse_frx();
        chk("credit_48", 32'(credit), 32'd48);
        pulse_frx();
        chk("credit_56", 32'(credit), 32'd56);
        chk("cerr_0", 32'(credit_error), 32'd0);
        pulse_frx();
        chk("credit_hold", 32'(credit), 32'd56);
        chk("cerr_1", 32'(credit_error), 32'd1);
        fifo_valid = 1'b1;
        fifo_data  = 9'h100;
        get_char(4, 1'b0, bits);
        chk("eop", 32'(bits), 32'b0101);
        chk("rd_eop", 32'(n_rd), 32'd1);
        chk("credit_55", 32'(credit), 32'd55);
        fifo_valid = 1'b0;
        get_char(8, 1'b0, bits);
        chk("null_after_eop", 32'(bits), 32'b11110100);
        fifo_valid = 1'b1;
        fifo_data  = 9'h1FF;
        get_char(4, 1'b0, bits);
        chk("eep", 32'(bits), 32'b0110);
        chk("credit_54", 32'(credit), 32'd54);
        fifo_valid = 1'b0;

        // disable keeps credit_error; same-cycle select + FCT gives net +7
        tx_enable = 1'b0;
        cyc();
        chk("dis_credit", 32'(credit), 32'd0);
        chk("dis_cerr", 32'(credit_error), 32'd1);
        tx_enable = 1'b1;
        get_char(8, 1'b0, bits);
        chk("reen2_null", 32'(bits), 32'b01110100);
        pulse_frx();
        fifo_valid = 1'b1;
        fifo_data  = 9'h055;
        get_char(10, 1'b1, bits);
        chk("data_55", 32'(bits), 32'b1010101010);
        chk("credit_net7", 32'(credit), 32'd15);
        fifo_valid = 1'b0;

        // asynchronous reset mid character
        get_char(3, 1'b0, bits);
        reset = 1'b1;
        #1;
        chk("arst_dout", 32'(dout), 32'd0);
        chk("arst_sout", 32'(sout), 32'd0);
        chk("arst_credit", 32'(credit), 32'd0);
        chk("arst_cerr", 32'(credit_error), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
